cache_cmd_dispatch: RTL and testbench

- Upstream stage of the split L1 caches (8-way data, 4-way instruction, 16K sets, 32-bit address).
- Accepts trace commands (code + address) over a valid/ready handshake.
- Splits the address into tag (12 bits), index (14 bits) and byte (6 bits), then issues one request at a time to the data or instruction cache and waits for its hit/miss response.
- Keeps saturating hit/miss/access statistics, and sequences clear and print commands.

---
 rtl/cache_cmd_dispatch_pkg.sv | 67 ++++++
 rtl/cache_cmd_dispatch_fifo.sv | 45 ++++
 rtl/cache_cmd_dispatch.sv | 164 ++++++++++++++++
 tb/tb_cache_cmd_dispatch.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cmd_dispatch_pkg.sv
// Shared definitions for the L1 trace command dispatcher: trace codes, cache ops,
// dispatcher states, statistic selectors and small decode helpers.
package cache_cmd_dispatch_pkg;

  localparam int TagAddr_size   = 12;
  localparam int IndexAddr_size = 14;
  localparam int ByteAddr_size  = 6;
  localparam int TraceAddr_size = TagAddr_size + IndexAddr_size + ByteAddr_size;
  localparam int StatCnt_size   = 32;

  typedef enum logic [3:0] {
    TC_READ   = 4'd0,
    TC_WRITE  = 4'd1,
    TC_IFETCH = 4'd2,
    TC_INVAL  = 4'd3,
    TC_SNOOP  = 4'd4,
    TC_CLEAR  = 4'd8,
    TC_PRINT  = 4'd9
  } trace_cmd_t;

  typedef enum logic [2:0] {
    OP_RD     = 3'd0,
    OP_WR     = 3'd1,
    OP_IFETCH = 3'd2,
    OP_INVAL  = 3'd3,
    OP_SNOOP  = 3'd4
  } cache_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CLEAR,
    ST_PRINT
  } disp_state_t;

  localparam logic [2:0] STAT_DRD    = 3'd0;
  localparam logic [2:0] STAT_DWR    = 3'd1;
  localparam logic [2:0] STAT_DHIT   = 3'd2;
  localparam logic [2:0] STAT_DMISS  = 3'd3;
  localparam logic [2:0] STAT_IFETCH = 3'd4;
  localparam logic [2:0] STAT_IHIT   = 3'd5;
  localparam logic [2:0] STAT_IMISS  = 3'd6;
  localparam logic [2:0] STAT_BAD    = 3'd7;

  // Codes 0-4 become cache requests; 8 and 9 are sequencing commands.
  function automatic logic cmd_is_mem(input logic [3:0] code);
    return code <= 4'd4;
  endfunction

  function automatic logic cmd_is_bad(input logic [3:0] code);
    return !(cmd_is_mem(code) || code == TC_CLEAR || code == TC_PRINT);
  endfunction

  function automatic cache_op_t cmd_to_op(input logic [3:0] code);
    cache_op_t op;
    case (code)
      TC_WRITE:  op = OP_WR;
      TC_IFETCH: op = OP_IFETCH;
      TC_INVAL:  op = OP_INVAL;
      TC_SNOOP:  op = OP_SNOOP;
      default:   op = OP_RD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cache_cmd_dispatch_fifo.sv
// Synchronous command FIFO (no bypass); a push when full is refused even with a pop.
module cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cache_cmd_dispatch.sv
// Trace command dispatcher for the split L1 caches: decodes commands, issues one cache
// request at a time and keeps saturating statistics. Define CMD_FIFO_EN for a command FIFO.
module cache_cmd_dispatch
  import cache_cmd_dispatch_pkg::*;
#(
  parameter int ADDR_W = TraceAddr_size,
  parameter int TAG_W  = TagAddr_size,
  parameter int IDX_W  = IndexAddr_size,
  parameter int BYTE_W = ByteAddr_size,
  parameter int CNT_W  = StatCnt_size
`ifdef CMD_FIFO_EN
  ,
  parameter int FIFO_DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_code,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_sel,
  output logic [2:0]        req_op,
  output logic [TAG_W-1:0]  req_tag,
  output logic [IDX_W-1:0]  req_index,
  output logic [BYTE_W-1:0] req_byte,
  input  logic              resp_valid,
  input  logic              resp_hit,
  output logic              clear_o,
  output logic              print_req,
  input  logic              print_done,
  output logic              bad_cmd,
  input  logic [2:0]        stat_sel,
  output logic [CNT_W-1:0]  stat_data
);

  disp_state_t       state_q;
  disp_state_t       state_d;
  logic              src_valid;
  logic [3:0]        src_code;
  logic [ADDR_W-1:0] src_addr;
  logic              src_take;
  logic              bad_take;
  logic              resp_fire;
  cache_op_t         op_q;
  logic [CNT_W-1:0]  cnt [8];

`ifdef CMD_FIFO_EN
  localparam int CMD_W = 4 + ADDR_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dout;

  cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_code, cmd_addr}),
    .pop   (src_take),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready             = rst_n && !fifo_full;
  assign src_valid             = !fifo_empty;
  assign {src_code, src_addr}  = fifo_dout;
`else
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign src_valid = cmd_valid;
  assign src_code  = cmd_code;
  assign src_addr  = cmd_addr;
`endif

  assign bad_take  = src_take && cmd_is_bad(src_code);
  assign resp_fire = (state_q == ST_WAIT) && resp_valid;
  assign req_op    = op_q;
  assign stat_data = cnt[stat_sel];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (src_valid) begin
          if (cmd_is_mem(src_code))       state_d = ST_ISSUE;
          else if (src_code == TC_CLEAR)  state_d = ST_CLEAR;
          else if (src_code == TC_PRINT)  state_d = ST_PRINT;
        end
      end
      ST_ISSUE: if (req_ready)  state_d = ST_WAIT;
      ST_WAIT:  if (resp_valid) state_d = ST_IDLE;
      ST_CLEAR: state_d = ST_IDLE;
      ST_PRINT: if (print_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_take  = (state_q == ST_IDLE) && src_valid;
    req_valid = (state_q == ST_ISSUE);
    clear_o   = (state_q == ST_CLEAR);
    print_req = (state_q == ST_PRINT);
  end

  // Request fields are captured at acceptance and held until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sel   <= 1'b0;
      op_q      <= OP_RD;
      req_tag   <= '0;
      req_index <= '0;
      req_byte  <= '0;
      bad_cmd   <= 1'b0;
    end else begin
      bad_cmd <= bad_take;
      if (src_take && cmd_is_mem(src_code)) begin
        req_sel   <= (src_code == TC_IFETCH);
        op_q      <= cmd_to_op(src_code);
        req_tag   <= src_addr[ADDR_W-1 -: TAG_W];
        req_index <= src_addr[BYTE_W +: IDX_W];
        req_byte  <= src_addr[BYTE_W-1:0];
      end
    end
  end

  // Only RD/WR/IFETCH responses count; INVAL and SNOOP leave statistics untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      if (bad_take) cnt[STAT_BAD] <= sat_inc(cnt[STAT_BAD]);
      if (resp_fire) begin
        if (!req_sel && (op_q == OP_RD || op_q == OP_WR)) begin
          if (op_q == OP_RD) cnt[STAT_DRD] <= sat_inc(cnt[STAT_DRD]);
          else               cnt[STAT_DWR] <= sat_inc(cnt[STAT_DWR]);
          if (resp_hit) cnt[STAT_DHIT]  <= sat_inc(cnt[STAT_DHIT]);
          else          cnt[STAT_DMISS] <= sat_inc(cnt[STAT_DMISS]);
        end else if (req_sel && op_q == OP_IFETCH) begin
          cnt[STAT_IFETCH] <= sat_inc(cnt[STAT_IFETCH]);
          if (resp_hit) cnt[STAT_IHIT]  <= sat_inc(cnt[STAT_IHIT]);
          else          cnt[STAT_IMISS] <= sat_inc(cnt[STAT_IMISS]);
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_cmd_dispatch.sv
// Self-checking bench for cache_cmd_dispatch: randomized traces against a behavioural
// model of the decode rules and statistics.
`timescale 1ns/1ps
module tb_cache_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        req_valid;
  logic        req_ready;
  logic        req_sel;
  logic [2:0]  req_op;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_byte;
  logic        resp_valid;
  logic        resp_hit;
  logic        clear_o;
  logic        print_req;
  logic        print_done;
  logic        bad_cmd;
  logic [2:0]  stat_sel;
  logic [31:0] stat_data;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  longint model_cnt [8];

  cache_cmd_dispatch dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_op(req_op), .req_tag(req_tag), .req_index(req_index),
    .req_byte(req_byte), .resp_valid(resp_valid), .resp_hit(resp_hit), .clear_o(clear_o),
    .print_req(print_req), .print_done(print_done), .bad_cmd(bad_cmd),
    .stat_sel(stat_sel), .stat_data(stat_data)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint bump(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Statistic rules: reads/writes/fetches plus hit/miss per cache; others untouched.
  task automatic model_resp(input int code, input bit hit);
    case (code)
      0: begin model_cnt[0] = bump(model_cnt[0]); if (hit) model_cnt[2] = bump(model_cnt[2]); else model_cnt[3] = bump(model_cnt[3]); end
      1: begin model_cnt[1] = bump(model_cnt[1]); if (hit) model_cnt[2] = bump(model_cnt[2]); else model_cnt[3] = bump(model_cnt[3]); end
      2: begin model_cnt[4] = bump(model_cnt[4]); if (hit) model_cnt[5] = bump(model_cnt[5]); else model_cnt[6] = bump(model_cnt[6]); end
      default: ;
    endcase
  endtask

  function automatic logic [35:0] exp_fields(input int code, input logic [31:0] a);
    logic       sel;
    logic [2:0] op;
    sel = (code == 2);
    op  = 3'(code);
    return {sel, op, 12'((a >> 20) & 32'hFFF), 14'((a >> 6) & 32'h3FFF), 6'(a & 32'h3F)};
  endfunction

  function automatic logic [3:0] rand_bad_code();
    logic [3:0] c;
    c = 4'($urandom_range(5, 15));
    if (c == 4'd8 || c == 4'd9) c = 4'd7;
    return c;
  endfunction

  task automatic send_cmd(input logic [3:0] code, input logic [31:0] addr, output bit ok);
    int n = 0;
    cmd_code  = code;
    cmd_addr  = addr;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin step(); n++; end
    ok = cmd_ready;
    step();
    cmd_valid = 1'b0;
  endtask

  // Drives one cache transaction end to end and reports what the DUT presented.
  task automatic run_mem(input int code, input logic [31:0] addr, input bit hit, input int stall,
                         input int rdelay, input bit spur, output bit ok, output logic [35:0] fields,
                         output int hold, output bit stable, output bit dropped, output bit rdy_low);
    int n = 0;
    hold = 0; stable = 1'b1; dropped = 1'b1; rdy_low = 1'b1; fields = '0;
    send_cmd(4'(code), addr, ok);
    if (!ok) return;
    while (!req_valid && n < 10) begin step(); n++; end
    if (!req_valid) begin ok = 1'b0; return; end
    fields = {req_sel, req_op, req_tag, req_index, req_byte};
    req_ready = 1'b0;
    repeat (stall) begin
      if (req_valid) hold++;
      if ({req_sel, req_op, req_tag, req_index, req_byte} !== fields || !req_valid) stable = 1'b0;
      if (cmd_ready) rdy_low = 1'b0;
      step();
    end
    if (!req_valid) stable = 1'b0;
    req_ready  = 1'b1;
    resp_valid = spur;
    resp_hit   = 1'b1;
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    if (req_valid) dropped = 1'b0;
    repeat (rdelay) begin
      if (cmd_ready) rdy_low = 1'b0;
      step();
    end
    if (cmd_ready) rdy_low = 1'b0;
    resp_valid = 1'b1;
    resp_hit   = hit;
    step();
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    model_resp(code, hit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({cmd_ready, req_valid, clear_o, print_req, bad_cmd} !== 5'b0) begin
      n_bad++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {cmd_ready, req_valid, clear_o, print_req, bad_cmd});
    end
    n_cmp++;
    if ({req_sel, req_op, req_tag, req_index, req_byte} !== 36'h0) begin
      n_bad++; $display("[TB] FAIL reset_fields: got %h expected 0", {req_sel, req_op, req_tag, req_index, req_byte});
    end
    for (int i = 0; i < 8; i++) begin
      model_cnt[i] = 0;
      stat_sel = 3'(i); #1;
      n_cmp++;
      if (stat_data !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_stat%0d: got %0h expected 0", i, stat_data); end
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_read_miss();
    bit ok, st, dr, rl; logic [35:0] f; int h;
    run_mem(0, 32'h1234_5678, 1'b0, 0, 0, 1'b0, ok, f, h, st, dr, rl);
    n_cmp++;
    if (!ok || f !== {1'b0, 3'd0, 12'h123, 14'h1159, 6'h38}) begin
      n_bad++; $display("[TB] FAIL read_fields: got %h ok=%0d expected %h", f, ok, {1'b0, 3'd0, 12'h123, 14'h1159, 6'h38});
    end
    stat_sel = 3'd0; #1; n_cmp++;
    if (stat_data !== 32'(model_cnt[0])) begin n_bad++; $display("[TB] FAIL read_stat0: got %0d expected %0d", stat_data, model_cnt[0]); end
    stat_sel = 3'd3; #1; n_cmp++;
    if (stat_data !== 32'(model_cnt[3])) begin n_bad++; $display("[TB] FAIL read_stat3: got %0d expected %0d", stat_data, model_cnt[3]); end
  endtask

  task automatic test_ifetch_hit();
    bit ok, st, dr, rl; logic [35:0] f; int h;
    run_mem(2, 32'hFFFF_FFC0, 1'b1, 0, 1, 1'b0, ok, f, h, st, dr, rl);
    n_cmp++;
    if (!ok || f !== {1'b1, 3'd2, 12'hFFF, 14'h3FFF, 6'h00}) begin
      n_bad++; $display("[TB] FAIL ifetch_fields: got %h ok=%0d expected %h", f, ok, {1'b1, 3'd2, 12'hFFF, 14'h3FFF, 6'h00});
    end
    for (int i = 4; i < 7; i++) begin
      stat_sel = 3'(i); #1; n_cmp++;
      if (stat_data !== 32'(model_cnt[i])) begin n_bad++; $display("[TB] FAIL ifetch_stat%0d: got %0d expected %0d", i, stat_data, model_cnt[i]); end
    end
  endtask

  task automatic test_snoop_stall();
    bit ok, st, dr, rl; logic [35:0] f; int h;
    run_mem(4, 32'hA5A5_1234, 1'b1, 5, 2, 1'b1, ok, f, h, st, dr, rl);
    n_cmp++;
    if (!ok || h != 5 || !st || !dr) begin
      n_bad++; $display("[TB] FAIL snoop_hold: got hold=%0d stable=%0d drop=%0d ok=%0d expected 5/1/1/1", h, st, dr, ok);
    end
    n_cmp++;
    if (f !== exp_fields(4, 32'hA5A5_1234)) begin n_bad++; $display("[TB] FAIL snoop_fields: got %h expected %h", f, exp_fields(4, 32'hA5A5_1234)); end
`ifndef CMD_FIFO_EN
    n_cmp++;
    if (!rl) begin n_bad++; $display("[TB] FAIL snoop_ready: got cmd_ready high while busy expected low"); end
`endif
    for (int i = 0; i < 8; i++) begin
      stat_sel = 3'(i); #1; n_cmp++;
      if (stat_data !== 32'(model_cnt[i])) begin n_bad++; $display("[TB] FAIL snoop_stat%0d: got %0d expected %0d", i, stat_data, model_cnt[i]); end
    end
  endtask

  task automatic test_clear();
    bit ok, st, dr, rl; logic [35:0] f; int h, pulses;
    for (int k = 0; k < 3; k++) run_mem(0, $urandom, 1'($urandom), 0, 0, 1'b0, ok, f, h, st, dr, rl);
    stat_sel = 3'd0; #1; n_cmp++;
    if (stat_data !== 32'(model_cnt[0])) begin n_bad++; $display("[TB] FAIL preclear_stat0: got %0d expected %0d", stat_data, model_cnt[0]); end
    send_cmd(4'd8, 32'h0, ok);
    pulses = 0;
    repeat (4) begin if (clear_o) pulses++; step(); end
    for (int i = 0; i < 8; i++) model_cnt[i] = 0;
    n_cmp++;
    if (!ok || pulses != 1) begin n_bad++; $display("[TB] FAIL clear_pulse: got %0d cycles expected 1", pulses); end
    stat_sel = 3'd0; #1; n_cmp++;
    if (stat_data !== 32'h0) begin n_bad++; $display("[TB] FAIL clear_stat0: got %0d expected 0", stat_data); end
  endtask

  task automatic test_print_bad();
    bit ok; int n, hi, pulses;
    send_cmd(4'd9, 32'h0, ok);
    n = 0;
    while (!print_req && n < 10) begin step(); n++; end
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (print_req) hi++;
      if (k == 9) print_done = 1'b1;
      step();
    end
    print_done = 1'b0;
    n_cmp++;
    if (!ok || hi != 10 || print_req !== 1'b0) begin
      n_bad++; $display("[TB] FAIL print_req: got %0d cycles, end=%b expected 10 cycles, end=0", hi, print_req);
    end
    send_cmd(4'd7, 32'h0, ok);
    pulses = 0;
    repeat (4) begin if (bad_cmd) pulses++; step(); end
    model_cnt[7] = bump(model_cnt[7]);
    n_cmp++;
    if (!ok || pulses != 1) begin n_bad++; $display("[TB] FAIL bad_pulse: got %0d cycles expected 1", pulses); end
    stat_sel = 3'd7; #1; n_cmp++;
    if (stat_data !== 32'(model_cnt[7])) begin n_bad++; $display("[TB] FAIL bad_stat7: got %0d expected %0d", stat_data, model_cnt[7]); end
  endtask

  task automatic test_back_to_back();
    bit ok, st, dr, rl; logic [35:0] f; int h, c0, exp_cyc;
`ifdef CMD_FIFO_EN
    exp_cyc = 4;
`else
    exp_cyc = 3;
`endif
    for (int k = 0; k < 4; k++) begin
      c0 = cyc;
      run_mem(k % 2, $urandom, 1'b1, 0, 0, 1'b0, ok, f, h, st, dr, rl);
      n_cmp++;
      if (!ok || cyc - c0 != exp_cyc) begin n_bad++; $display("[TB] FAIL b2b_cycles: got %0d expected %0d", cyc - c0, exp_cyc); end
    end
  endtask

  task automatic test_random();
    bit ok, st, dr, rl; logic [35:0] f; int h, r, code, pulses; logic [31:0] a;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 11);
      if (r == 10) begin
        send_cmd(4'd8, 32'h0, ok);
        repeat (3) step();
        for (int i = 0; i < 8; i++) model_cnt[i] = 0;
      end else if (r == 11) begin
        send_cmd(rand_bad_code(), $urandom, ok);
        pulses = 0;
        repeat (3) begin if (bad_cmd) pulses++; step(); end
        model_cnt[7] = bump(model_cnt[7]);
        n_cmp++;
        if (!ok || pulses != 1) begin n_bad++; $display("[TB] FAIL rand_bad: got %0d pulses expected 1", pulses); end
      end else begin
        code = r % 5;
        a = $urandom;
        run_mem(code, a, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), ok, f, h, st, dr, rl);
        n_cmp++;
        if (!ok || f !== exp_fields(code, a) || !st || !dr) begin
          n_bad++; $display("[TB] FAIL rand_fields: got %h st=%0d dr=%0d expected %h", f, st, dr, exp_fields(code, a));
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      stat_sel = 3'(i); #1; n_cmp++;
      if (stat_data !== 32'(model_cnt[i])) begin n_bad++; $display("[TB] FAIL rand_stat%0d: got %0d expected %0d", i, stat_data, model_cnt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int n;
    send_cmd(4'd0, 32'hDEAD_BEEF, ok);
    n = 0;
    while (!req_valid && n < 10) begin step(); n++; end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || req_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL midreset: got req_valid=%b cmd_ready=%b expected 0/0", req_valid, cmd_ready);
    end
    step();
    resp_valid = 1'b1; resp_hit = 1'b1;
    rst_n = 1'b1;
    step();
    resp_valid = 1'b0;
    for (int i = 0; i < 8; i++) model_cnt[i] = 0;
    n_cmp++;
    if (cmd_ready !== 1'b1 || req_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL midreset_idle: got cmd_ready=%b req_valid=%b expected 1/0", cmd_ready, req_valid);
    end
    for (int i = 0; i < 8; i++) begin
      stat_sel = 3'(i); #1; n_cmp++;
      if (stat_data !== 32'h0) begin n_bad++; $display("[TB] FAIL midreset_stat%0d: got %0d expected 0", i, stat_data); end
    end
  endtask

`ifdef CMD_FIFO_EN
  task automatic test_fifo_full();
    int n; bit all_ready = 1'b1;
    req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1; cmd_code = 4'd4; cmd_addr = $urandom;
      if (!cmd_ready) all_ready = 1'b0;
      step();
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!all_ready || cmd_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL fifo_full: got ready_during=%0d ready_at_full=%b expected 1/0", all_ready, cmd_ready);
    end
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!req_valid && n < 10) begin step(); n++; end
      req_ready = 1'b1; step(); req_ready = 1'b0;
      resp_valid = 1'b1; step(); resp_valid = 1'b0;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL fifo_drain: got %b expected 1", cmd_ready); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 4'd0; cmd_addr = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0; print_done = 1'b0; stat_sel = 3'd0;
    test_reset();
    test_read_miss();
    test_ifetch_hit();
    test_snoop_stall();
    test_clear();
    test_print_bad();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef CMD_FIFO_EN
    test_fifo_full();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
